mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 120 ++++++++++++
 tb/tb_mem_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of a shared single-ported word memory; one access per two cycles.
// Define MEM_ARBITER_ROUND_ROBIN_EN for round-robin arbitration; the default is fixed priority to requester 0.
module mem_arbiter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SIZE  = 4,
  localparam int unsigned AW   = (SIZE > 1) ? $clog2(SIZE) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             we0,
  input  logic [AW-1:0]    addr0,
  input  logic [WIDTH-1:0] wdata0,
  output logic             gnt0,
  output logic             rvalid0,
  output logic [WIDTH-1:0] rdata0,
  input  logic             req1,
  input  logic             we1,
  input  logic [AW-1:0]    addr1,
  input  logic [WIDTH-1:0] wdata1,
  output logic             gnt1,
  output logic             rvalid1,
  output logic [WIDTH-1:0] rdata1,
  output logic             busy
);

  typedef enum logic {IDLE, SERVE} state_t;

  state_t           state;
  logic             owner;
  logic             winner;
  logic             serve;
  logic             sel_we;
  logic [AW-1:0]    sel_addr;
  logic [WIDTH-1:0] sel_wdata;
  logic [WIDTH-1:0] rd_word;
  logic             in_range;
  logic [WIDTH-1:0] mem [SIZE];

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  logic last;

  // On a tie the requester not granted last time wins.
  always_comb begin
    winner = req1;
    if (req0 && req1) winner = ~last;
  end
`else
  always_comb begin
    winner = ~req0;
  end
`endif

  // Only a non-power-of-two depth can see addresses past the end of the array.
  if (SIZE == (1 << AW)) begin : g_full
    assign in_range = 1'b1;
  end else begin : g_part
    assign in_range = (32'(sel_addr) < SIZE);
  end

  // Owner's bus is used live during SERVE; grants decode straight from state.
  always_comb begin
    serve     = (state == SERVE);
    gnt0      = serve && !owner;
    gnt1      = serve && owner;
    busy      = serve;
    sel_we    = owner ? we1    : we0;
    sel_addr  = owner ? addr1  : addr0;
    sel_wdata = owner ? wdata1 : wdata0;
    rd_word   = '0;
    if (in_range) rd_word = mem[sel_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      owner   <= 1'b0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      last    <= 1'b1;
`endif
    end else begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            owner <= winner;
            state <= SERVE;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
            last  <= winner;
`endif
          end
        end
        SERVE: begin
          state <= IDLE;
          if (!sel_we) begin
            if (owner) begin
              rdata1  <= rd_word;
              rvalid1 <= 1'b1;
            end else begin
              rdata0  <= rd_word;
              rvalid0 <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Storage is not reset; a reset during SERVE forces IDLE so the write never fires.
  always_ff @(posedge clk) begin
    if (serve && sel_we && in_range) mem[sel_addr] <= sel_wdata;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter at default WIDTH=8, SIZE=4.
module tb_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0, we0, req1, we1;
  logic [1:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic       gnt0, gnt1, rvalid0, rvalid1, busy;
  logic [7:0] rdata0, rdata1;
  int         checks   = 0;
  int         failures = 0;
  logic       e;

  mem_arbiter #(.WIDTH(8), .SIZE(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    req0 = 1'b0;
    req1 = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // One complete protocol-respecting access; returns in the cycle after SERVE.
  task automatic access(input bit r, input bit we, input logic [1:0] a, input logic [7:0] d);
    if (r) begin
      req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d;
    end else begin
      req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d;
    end
    tick();
    chk1("acc_gnt", r ? gnt1 : gnt0, 1'b1);
    tick();
    req0 = 1'b0;
    req1 = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    req0 = 1'b0; we0 = 1'b0; addr0 = 2'd0; wdata0 = 8'h00;
    req1 = 1'b0; we1 = 1'b0; addr1 = 2'd0; wdata1 = 8'h00;

    // Reset values before any clock edge.
    #2;
    chk1("rst_gnt0", gnt0, 1'b0);
    chk1("rst_gnt1", gnt1, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_rvalid0", rvalid0, 1'b0);
    chk1("rst_rvalid1", rvalid1, 1'b0);
    chk8("rst_rdata0", rdata0, 8'h00);
    chk8("rst_rdata1", rdata1, 8'h00);
    tick();
    tick();
    rst_n = 1'b1;

    // Write 0xA5 to addr 2, then read it back.
    req0 = 1'b1; we0 = 1'b1; addr0 = 2'd2; wdata0 = 8'hA5;
    chk1("wr_idle_busy", busy, 1'b0);
    tick();
    chk1("wr_gnt0", gnt0, 1'b1);
    chk1("wr_gnt1", gnt1, 1'b0);
    chk1("wr_busy", busy, 1'b1);
    tick();
    req0 = 1'b0;
    chk1("wr_gnt0_off", gnt0, 1'b0);
    chk1("wr_busy_off", busy, 1'b0);
    chk1("wr_no_rvalid", rvalid0, 1'b0);
    req0 = 1'b1; we0 = 1'b0; addr0 = 2'd2;
    tick();
    chk1("rd_gnt0", gnt0, 1'b1);
    chk1("rd_rvalid_early", rvalid0, 1'b0);
    tick();
    req0 = 1'b0;
    chk1("rd_rvalid0", rvalid0, 1'b1);
    chk8("rd_rdata0", rdata0, 8'hA5);
    chk1("rd_gnt0_off", gnt0, 1'b0);
    tick();
    chk1("rd_rvalid_pulse", rvalid0, 1'b0);
    chk8("rd_rdata_hold", rdata0, 8'hA5);

    // Preload via both requesters and read back through requester 1.
    access(1'b1, 1'b1, 2'd1, 8'h11);
    access(1'b0, 1'b1, 2'd0, 8'h50);
    access(1'b0, 1'b1, 2'd3, 8'h77);
    access(1'b1, 1'b0, 2'd1, 8'h00);
    chk1("r1_rvalid1", rvalid1, 1'b1);
    chk1("r1_rvalid0", rvalid0, 1'b0);
    chk8("r1_rdata1", rdata1, 8'h11);

    // Both requesters held high continuously.
    do_reset();
    req0 = 1'b1; we0 = 1'b0; addr0 = 2'd0;
    req1 = 1'b1; we1 = 1'b0; addr1 = 2'd1;
    for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      e = ((k % 2) == 1);
`else
      e = 1'b0;
`endif
      tick();
      chk1("tie_gnt0", gnt0, !e);
      chk1("tie_gnt1", gnt1, e);
      tick();
      chk1("tie_rvalid0", rvalid0, !e);
      chk1("tie_rvalid1", rvalid1, e);
      if (e) chk8("tie_rdata1", rdata1, 8'h11);
      else   chk8("tie_rdata0", rdata0, 8'h50);
    end
    req0 = 1'b0;
    req1 = 1'b0;

    // Same-cycle read (req0) and write (req1) of addr 3 just after reset.
    do_reset();
    req0 = 1'b1; we0 = 1'b0; addr0 = 2'd3;
    req1 = 1'b1; we1 = 1'b1; addr1 = 2'd3; wdata1 = 8'h3C;
    tick();
    chk1("rw_first_gnt0", gnt0, 1'b1);
    chk1("rw_first_gnt1", gnt1, 1'b0);
    tick();
    req0 = 1'b0;
    chk1("rw_old_rvalid0", rvalid0, 1'b1);
    chk8("rw_old_rdata0", rdata0, 8'h77);
    tick();
    chk1("rw_second_gnt1", gnt1, 1'b1);
    chk1("rw_second_gnt0", gnt0, 1'b0);
    tick();
    req1 = 1'b0;
    access(1'b0, 1'b0, 2'd3, 8'h00);
    chk8("rw_new_rdata0", rdata0, 8'h3C);

    // Reset during SERVE of a write aborts it.
    req0 = 1'b1; we0 = 1'b1; addr0 = 2'd1; wdata0 = 8'hFF;
    tick();
    chk1("ab_gnt0", gnt0, 1'b1);
    chk1("ab_busy", busy, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk1("ab_gnt0_drop", gnt0, 1'b0);
    chk1("ab_busy_drop", busy, 1'b0);
    req0 = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    chk1("ab_no_rvalid", rvalid0, 1'b0);
    access(1'b0, 1'b0, 2'd1, 8'h00);
    chk1("ab_rvalid0", rvalid0, 1'b1);
    chk8("ab_rdata0", rdata0, 8'h11);

    // Single requester holding req high back-to-back.
    req0 = 1'b1; we0 = 1'b0; addr0 = 2'd2;
    for (int k = 0; k < 6; k++) begin
      e = ((k % 2) == 0);
      tick();
      chk1("b2b_busy", busy, e);
      chk1("b2b_gnt0", gnt0, e);
      chk1("b2b_rvalid0", rvalid0, !e);
    end
    req0 = 1'b0;
    chk8("b2b_rdata0", rdata0, 8'hA5);

    // Request withdrawn in IDLE before any edge: no side effect.
    req0 = 1'b1; we0 = 1'b1; addr0 = 2'd2; wdata0 = 8'h99;
    #2 req0 = 1'b0;
    tick();
    chk1("wd_busy", busy, 1'b0);
    access(1'b0, 1'b0, 2'd2, 8'h00);
    chk8("wd_rdata0", rdata0, 8'hA5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
